// File: rtl/restoring_divider_ctrl_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential 4-bit divider.
// The master issues divide requests and the slave (the divider) returns results.
interface restoring_divider_ctrl_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_ctrl.sv
// Multi-cycle 4-bit unsigned restoring divider sharing one adder-subtractor in subtract mode.
// One quotient bit per cycle over four cycles; a zero divisor is answered in one cycle.
module four_bit_adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] S,
  output logic       C,
  output logic       V
);
  logic [3:0] bEff;
  logic [4:0] carry;

  assign bEff     = B ^ {4{M}};
  assign carry[0] = M;

  for (genvar i = 0; i < 4; i++) begin : gRipple
    assign S[i]       = A[i] ^ bEff[i] ^ carry[i];
    assign carry[i+1] = (A[i] & bEff[i]) | (carry[i] & (A[i] ^ bEff[i]));
  end

  assign C = carry[4];
  assign V = carry[4] ^ carry[3];
endmodule

module restoring_divider_ctrl (
  input logic                     clk,
  input logic                     rst,
  restoring_divider_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} stateType;

  stateType   state, nextState;
  logic [3:0] rReg, qwReg, dReg;
  logic [1:0] cnt;
  logic       doneReg, divByZeroReg;
  logic [3:0] quotientReg, remainderReg;

  logic       load, iterate, finish, zeroDiv;
  logic [3:0] shifted, diff, nextR, nextQw;
  logic       carryOut;
  logic       unusedOverflow;
  logic       unusedRemTop;

  // R stays below D, so its top bit is always 0 before the shift and drops out here.
  assign shifted      = {rReg[2:0], qwReg[3]};
  assign unusedRemTop = rReg[3];

  four_bit_adder_subtractor uAddSub (
    .A(shifted),
    .B(dReg),
    .M(1'b1),
    .S(diff),
    .C(carryOut),
    .V(unusedOverflow)
  );

  // Carry-out of A + ~B + 1 is set exactly when shifted >= divisor.
  assign nextR  = carryOut ? diff : shifted;
  assign nextQw = {qwReg[2:0], carryOut};

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    zeroDiv   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == 4'd0) begin
            zeroDiv = 1'b1;
          end else begin
            load      = 1'b1;
            nextState = RUN;
          end
        end
      end
      RUN: begin
        iterate = 1'b1;
        if (cnt == 2'd3) begin
          finish    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rReg         <= 4'd0;
      qwReg        <= 4'd0;
      dReg         <= 4'd0;
      cnt          <= 2'd0;
      doneReg      <= 1'b0;
      divByZeroReg <= 1'b0;
      quotientReg  <= 4'd0;
      remainderReg <= 4'd0;
    end else begin
      doneReg <= 1'b0;
      if (load) begin
        rReg  <= 4'd0;
        qwReg <= bus.dividend;
        dReg  <= bus.divisor;
        cnt   <= 2'd0;
      end else if (iterate) begin
        rReg  <= nextR;
        qwReg <= nextQw;
        cnt   <= cnt + 2'd1;
      end
      if (finish) begin
        quotientReg  <= nextQw;
        remainderReg <= nextR;
        divByZeroReg <= 1'b0;
        doneReg      <= 1'b1;
      end
      if (zeroDiv) begin
        quotientReg  <= 4'hF;
        remainderReg <= bus.dividend;
        divByZeroReg <= 1'b1;
        doneReg      <= 1'b1;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = doneReg;
  assign bus.quotient    = quotientReg;
  assign bus.remainder   = remainderReg;
  assign bus.div_by_zero = divByZeroReg;
endmodule
